// File: rtl/i2c_target_tx.sv
// I2C read-only target: matches ADDR with R/W=1, ACKs, then streams bytes from a valid/ready source until the master NACKs.
// Optional clock stretching on an empty source is enabled with the I2C_STRETCH_EN macro.
module i2c_target_tx #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       master_nack,
  output logic       underrun,
  output logic [7:0] byte_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_TX_BYTE, ST_RX_ACK, ST_WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [7:0]             shreg;
  logic [2:0]             cnt;
  logic                   phase;   // ACK slot: address ACK driven / master ACK seen
  logic                   stall;
  logic                   scl_cur, scl_prv, sda_cur, sda_prv;
  logic                   scl_rise, scl_fall, start, stop, load_slot;

  // Bit 0 is the newest sample; the two oldest flops provide levels and edges.
  assign scl_cur   = scl_sync[SYNC_STAGES-2];
  assign scl_prv   = scl_sync[SYNC_STAGES-1];
  assign sda_cur   = sda_sync[SYNC_STAGES-2];
  assign sda_prv   = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_cur & ~scl_prv;
  assign scl_fall  = ~scl_cur & scl_prv;
  assign start     = scl_cur & scl_prv & ~sda_cur & sda_prv;
  assign stop      = scl_cur & scl_prv & sda_cur & ~sda_prv;
  assign load_slot = scl_fall & phase & ((state == ST_ADDR_ACK) | (state == ST_RX_ACK));

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync    <= '1;
      sda_sync    <= '1;
      state       <= ST_IDLE;
      shreg       <= 8'h00;
      cnt         <= 3'd0;
      phase       <= 1'b0;
      stall       <= 1'b0;
      sda_oe      <= 1'b0;
      scl_oe      <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      master_nack <= 1'b0;
      underrun    <= 1'b0;
      byte_cnt    <= 8'd0;
    end else begin
      scl_sync    <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync    <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      tx_ready    <= 1'b0;
      master_nack <= 1'b0;
      underrun    <= 1'b0;
      if (start) begin
        state    <= ST_ADDR;
        cnt      <= 3'd0;
        phase    <= 1'b0;
        stall    <= 1'b0;
        sda_oe   <= 1'b0;
        scl_oe   <= 1'b0;
        busy     <= 1'b0;
        byte_cnt <= 8'd0;
      end else if (stop) begin
        state  <= ST_IDLE;
        phase  <= 1'b0;
        stall  <= 1'b0;
        sda_oe <= 1'b0;
        scl_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        // SCL is let go one clk after the stalled byte's MSB is on SDA.
        if (scl_oe && !stall)
          scl_oe <= 1'b0;
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_cur};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (shreg[6:0] == ADDR && sda_cur) begin
                state <= ST_ADDR_ACK;
                busy  <= 1'b1;
                phase <= 1'b0;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall && !phase) begin
            sda_oe <= 1'b1;
            phase  <= 1'b1;
          end
          ST_TX_BYTE: if (scl_fall && !stall) begin
            if (cnt == 3'd7) begin
              sda_oe   <= 1'b0;
              byte_cnt <= byte_cnt + 8'd1;
              phase    <= 1'b0;
              state    <= ST_RX_ACK;
            end else begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
              cnt    <= cnt + 3'd1;
            end
          end
          ST_RX_ACK: if (scl_rise && !phase) begin
            if (sda_cur) begin
              master_nack <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_WAIT_STOP;
            end else begin
              phase <= 1'b1;
            end
          end
          default: ;
        endcase
        if (load_slot || stall) begin
          cnt   <= 3'd0;
          state <= ST_TX_BYTE;
          if (tx_valid) begin
            shreg    <= tx_data;
            sda_oe   <= ~tx_data[7];
            tx_ready <= 1'b1;
            stall    <= 1'b0;
          end else begin
`ifdef I2C_STRETCH_EN
            stall  <= 1'b1;
            scl_oe <= 1'b1;
            sda_oe <= 1'b0;
`else
            shreg    <= 8'hFF;
            sda_oe   <= 1'b0;
            underrun <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_tx.sv
// Bench for i2c_target_tx: a bit-banged I2C master plus a byte-level reference model of the expected read stream.
module tb_i2c_target_tx;
  localparam logic [6:0] OWN = 7'h50;
  localparam int SYNC = 2;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic scl_m = 1'b1, sda_m = 1'b1;
  logic scl_in, sda_in, sda_oe, scl_oe, tx_valid, tx_ready, busy, master_nack, underrun;
  logic [7:0] tx_data, byte_cnt;
  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  logic [7:0] src_mem [256];
  logic [7:0] wr_ptr = 8'd0, rd_ptr = 8'd0;
  assign tx_valid = (wr_ptr != rd_ptr);
  assign tx_data  = src_mem[rd_ptr];

  int total = 0, bad = 0;
  int n_rdy = 0, n_und = 0, n_nack = 0, n_oe = 0, n_busy = 0, n_scl = 0;
  logic [7:0] exp_b [8];
  int exp_rdy, exp_und;

  i2c_target_tx #(.ADDR(OWN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe), .scl_oe(scl_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .master_nack(master_nack), .underrun(underrun), .byte_cnt(byte_cnt)
  );

  always @(negedge clk) begin
    if (tx_ready) rd_ptr = rd_ptr + 8'd1;
    n_rdy  += int'(tx_ready);
    n_und  += int'(underrun);
    n_nack += int'(master_nack);
    n_oe   += int'(sda_oe);
    n_busy += int'(busy);
    n_scl  += int'(scl_oe);
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] v);
    src_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic clock_bit(input logic b, output logic r);
    int t;
    sda_m = b;
    wclk(Q);
    scl_m = 1'b1;
    t = 0;
    while (!scl_in && t < 400) begin
      wclk(1);
      t++;
    end
    chk("scl_high", scl_in, 1);
    wclk(Q);
    r = sda_in;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(v[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic get_bits(input int nb, output logic [7:0] v);
    logic r;
    v = 8'h00;
    for (int i = 0; i < nb; i++) begin
      clock_bit(1'b1, r);
      v = {v[6:0], r};
    end
  endtask

  // Expected stream: queued bytes in order, 0xFF for every slot the source cannot fill.
  task automatic fill_exp(input int n);
    logic [7:0] avail;
    avail = wr_ptr - rd_ptr;
    exp_rdy = 0;
    exp_und = 0;
    for (int i = 0; i < n; i++) begin
      if (i < int'(avail)) begin
        exp_b[i] = src_mem[rd_ptr + 8'(i)];
        exp_rdy++;
      end else begin
        exp_b[i] = 8'hFF;
        exp_und++;
      end
    end
  endtask

  task automatic read_txn(input int n);
    int rdy0, und0, nack0;
    logic ack, r;
    logic [7:0] v;
    rdy0 = n_rdy; und0 = n_und; nack0 = n_nack;
    i2c_start();
    send_byte({OWN, 1'b1}, ack);
    chk("addr_ack", ack, 0);
    chk("busy_on", busy, 1);
    chk("cnt_start", byte_cnt, 0);
    for (int i = 0; i < n; i++) begin
      get_bits(8, v);
      chk("rd_byte", v, exp_b[i]);
      clock_bit(i == n - 1, r);
    end
    chk("nack_pulses", n_nack - nack0, 1);
    chk("busy_off", busy, 0);
    chk("byte_cnt", byte_cnt, n);
    chk("rdy_pulses", n_rdy - rdy0, exp_rdy);
    chk("und_pulses", n_und - und0, exp_und);
    i2c_stop();
    wclk(4);
    chk("idle_oe", sda_oe, 0);
  endtask

  initial begin
    logic ack;
    logic [7:0] v;
    logic [6:0] bad_addr;
    int n, k, oe0, busy0, rdy0;

    wclk(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nack", master_nack, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    rst = 1'b0;
    wclk(5);

    // Single byte, master NACKs it.
    push(8'hA5);
    fill_exp(1);
    read_txn(1);

    // Three bytes: ACK, ACK, NACK.
    push(8'h11); push(8'h22); push(8'h33);
    fill_exp(3);
    read_txn(3);

    // Random lengths, source sometimes runs dry.
    repeat (5) begin
      n = $urandom_range(1, 4);
      k = $urandom_range(0, n);
      for (int i = 0; i < k; i++) push(8'($urandom));
      fill_exp(n);
      read_txn(n);
    end

    // Foreign address read, then write to own address: target stays silent.
    oe0 = n_oe; busy0 = n_busy; rdy0 = n_rdy;
    do bad_addr = 7'($urandom); while (bad_addr == OWN);
    push(8'h5A);
    i2c_start();
    send_byte({bad_addr, 1'b1}, ack);
    chk("foreign_noack", ack, 1);
    i2c_stop();
    i2c_start();
    send_byte({OWN, 1'b0}, ack);
    chk("write_noack", ack, 1);
    get_bits(8, v);
    chk("write_ignored", v, 8'hFF);
    i2c_stop();
    chk("silent_oe", n_oe - oe0, 0);
    chk("silent_busy", n_busy - busy0, 0);
    chk("silent_rdy", n_rdy - rdy0, 0);
    rd_ptr = wr_ptr;

    // Empty source at the first slot.
`ifdef I2C_STRETCH_EN
    fork
      begin
        int t;
        t = 0;
        while (!scl_oe && t < 2000) begin wclk(1); t++; end
        chk("stretch_on", scl_oe, 1);
        wclk(50);
        chk("scl_held", scl_in, 0);
        push(8'h3C);
      end
    join_none
    exp_b[0] = 8'h3C; exp_rdy = 1; exp_und = 0;
    read_txn(1);
    chk("stretch_off", scl_oe, 0);
`else
    fill_exp(1);
    read_txn(1);
    chk("no_stretch", n_scl, 0);
`endif

    // STOP in the middle of the second byte, then a fresh read.
    v = {4'($urandom), 4'hF};
    push(8'($urandom));
    push(v);
    fill_exp(1);
    i2c_start();
    send_byte({OWN, 1'b1}, ack);
    chk("ab_addr_ack", ack, 0);
    get_bits(8, v);
    chk("ab_byte0", v, exp_b[0]);
    clock_bit(1'b0, ack);
    get_bits(4, v);
    chk("ab_nibble", v[3:0], src_mem[wr_ptr - 8'd1][7:4]);
    chk("ab_cnt", byte_cnt, 1);
    chk("ab_busy", busy, 1);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1;
    wclk(SYNC + 1);
    chk("stop_release", sda_oe, 0);
    chk("stop_busy", busy, 0);
    wclk(Q);
    push(8'($urandom));
    fill_exp(2);
    read_txn(2);

    // Reset while the target is pulling SDA low mid-byte.
    push(8'h00);
    i2c_start();
    send_byte({OWN, 1'b1}, ack);
    chk("rr_addr_ack", ack, 0);
    get_bits(2, v);
    chk("rr_bits", v, 8'h00);
    chk("rr_driving", sda_oe, 1);
    rst = 1'b1;
    wclk(1);
    chk("rr_sda_oe", sda_oe, 0);
    chk("rr_scl_oe", scl_oe, 0);
    chk("rr_tx_ready", tx_ready, 0);
    chk("rr_busy", busy, 0);
    chk("rr_nack", master_nack, 0);
    chk("rr_underrun", underrun, 0);
    chk("rr_byte_cnt", byte_cnt, 0);
    rst = 1'b0;
    i2c_stop();
    wclk(Q);
    push(8'($urandom));
    push(8'($urandom));
    fill_exp(2);
    read_txn(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
